monitor_mux_sequencer: RTL and testbench

// Digital controller that drives the 40-bit one-hot Select code of the 40:1 monitoring analog MUX.
// It sequences channel selection, settling and monitoring-ADC conversion, in single-channel or masked-scan mode.

---
 rtl/monitor_mux_sequencer_if.sv | 34 +++
 rtl/monitor_mux_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_monitor_mux_sequencer.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/monitor_mux_sequencer_if.sv
// Signal bundle between the monitoring-MUX sequencer, its command source, the analog MUX and the monitoring ADC.
interface monitor_mux_sequencer_if #(
    parameter int N_CH  = 40,
    parameter int ADC_W = 12
);
    logic             start;
    logic             mode;
    logic [5:0]       ch_addr;
    logic [N_CH-1:0]  ch_mask;
    logic             abort;
    logic             adc_done;
    logic [ADC_W-1:0] adc_data;
    logic [N_CH-1:0]  select;
    logic             adc_start;
    logic             busy;
    logic             result_valid;
    logic [5:0]       result_ch;
    logic [ADC_W-1:0] result_data;
    logic             scan_done;
    logic             err_invalid_ch;
    logic             err_timeout;

    modport master (
        output start, mode, ch_addr, ch_mask, abort, adc_done, adc_data,
        input  select, adc_start, busy, result_valid, result_ch, result_data,
               scan_done, err_invalid_ch, err_timeout
    );

    modport slave (
        input  start, mode, ch_addr, ch_mask, abort, adc_done, adc_data,
        output select, adc_start, busy, result_valid, result_ch, result_data,
               scan_done, err_invalid_ch, err_timeout
    );
endinterface

// File: rtl/monitor_mux_sequencer.sv
// Drives the one-hot select of the monitoring analog MUX and sequences break, settle and ADC
// conversion for a single channel or an ascending masked scan; every output is registered.
module monitor_mux_sequencer #(
    parameter int N_CH           = 40,
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ADC_W          = 12
) (
    input  logic                   clk,
    input  logic                   rst_n,
    monitor_mux_sequencer_if.slave bus
);
    localparam int CH_W  = 6;
    localparam int MAX_C = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W = $clog2(MAX_C + 1);

    typedef enum logic [2:0] {IDLE, BREAK, SETTLE, CONVERT, WAIT, STORE} state_t;

    state_t           state_q, state_d;
    logic             mode_q, mode_d;
    logic [N_CH-1:0]  mask_q, mask_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_CH-1:0]  select_q, select_d;
    logic             adc_start_q, adc_start_d;
    logic             busy_q, busy_d;
    logic             result_valid_q, result_valid_d;
    logic [CH_W-1:0]  result_ch_q, result_ch_d;
    logic [ADC_W-1:0] result_data_q, result_data_d;
    logic             scan_done_q, scan_done_d;
    logic             err_inv_q, err_inv_d;
    logic             err_to_q, err_to_d;
    logic             leave;
    logic [CH_W:0]    first_hit, next_hit;

    // Lowest enabled channel at or above lo; MSB of the result flags that one was found.
    function automatic logic [CH_W:0] find_from(input logic [N_CH-1:0] m, input int lo);
        logic [CH_W:0] r;
        r = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (i >= lo && m[i]) r = {1'b1, CH_W'(i)};
        end
        return r;
    endfunction

    assign first_hit = find_from(bus.ch_mask, 0);
    assign next_hit  = find_from(mask_q, int'(ch_q) + 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            mode_q         <= 1'b0;
            mask_q         <= '0;
            ch_q           <= '0;
            cnt_q          <= '0;
            select_q       <= '0;
            adc_start_q    <= 1'b0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
            result_ch_q    <= '0;
            result_data_q  <= '0;
            scan_done_q    <= 1'b0;
            err_inv_q      <= 1'b0;
            err_to_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            mode_q         <= mode_d;
            mask_q         <= mask_d;
            ch_q           <= ch_d;
            cnt_q          <= cnt_d;
            select_q       <= select_d;
            adc_start_q    <= adc_start_d;
            busy_q         <= busy_d;
            result_valid_q <= result_valid_d;
            result_ch_q    <= result_ch_d;
            result_data_q  <= result_data_d;
            scan_done_q    <= scan_done_d;
            err_inv_q      <= err_inv_d;
            err_to_q       <= err_to_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        mode_d         = mode_q;
        mask_d         = mask_q;
        ch_d           = ch_q;
        cnt_d          = cnt_q;
        select_d       = select_q;
        adc_start_d    = 1'b0;
        result_valid_d = 1'b0;
        result_ch_d    = result_ch_q;
        result_data_d  = result_data_q;
        scan_done_d    = 1'b0;
        err_inv_d      = 1'b0;
        err_to_d       = 1'b0;
        leave          = 1'b0;

        if (bus.abort) begin
            state_d  = IDLE;
            select_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        select_d = '0;
                        mode_d   = bus.mode;
                        mask_d   = bus.ch_mask;
                        if (!bus.mode) begin
                            if (int'(bus.ch_addr) >= N_CH) begin
                                err_inv_d = 1'b1;
                            end else begin
                                ch_d    = bus.ch_addr;
                                state_d = BREAK;
                            end
                        end else if (first_hit[CH_W]) begin
                            ch_d    = first_hit[CH_W-1:0];
                            state_d = BREAK;
                        end else begin
                            scan_done_d = 1'b1;
                        end
                    end
                end
                BREAK: begin
                    state_d  = SETTLE;
                    select_d = {{(N_CH-1){1'b0}}, 1'b1} << ch_q;
                    cnt_d    = '0;
                end
                SETTLE: begin
                    if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                        state_d     = CONVERT;
                        adc_start_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                CONVERT: begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end
                WAIT: begin
                    // A conversion landing in the final wait cycle still counts as a result.
                    if (bus.adc_done) begin
                        state_d        = STORE;
                        result_valid_d = 1'b1;
                        result_ch_d    = ch_q;
                        result_data_d  = bus.adc_data;
                    end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        err_to_d = 1'b1;
                        leave    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                STORE: leave = 1'b1;
                default: begin
                    state_d  = IDLE;
                    select_d = '0;
                end
            endcase
        end

        // Single mode keeps the node routed for observation; a scan moves up or finishes.
        if (leave) begin
            if (!mode_q) begin
                state_d = IDLE;
            end else if (next_hit[CH_W]) begin
                state_d  = BREAK;
                ch_d     = next_hit[CH_W-1:0];
                select_d = '0;
            end else begin
                state_d     = IDLE;
                select_d    = '0;
                scan_done_d = 1'b1;
            end
        end

        busy_d = (state_d != IDLE);
    end

    assign bus.select         = select_q;
    assign bus.adc_start      = adc_start_q;
    assign bus.busy           = busy_q;
    assign bus.result_valid   = result_valid_q;
    assign bus.result_ch      = result_ch_q;
    assign bus.result_data    = result_data_q;
    assign bus.scan_done      = scan_done_q;
    assign bus.err_invalid_ch = err_inv_q;
    assign bus.err_timeout    = err_to_q;

    a_select_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(select_q));
endmodule

// File: tb/tb_monitor_mux_sequencer.sv
// Directed bench for the monitoring-MUX sequencer: inputs driven and outputs sampled on the falling edge,
// expected values worked out by hand for SETTLE_CYCLES=16 and TIMEOUT_CYCLES=255.
module tb_monitor_mux_sequencer;
    localparam int N_CH  = 40;
    localparam int ADC_W = 12;

    logic clk = 1'b0;
    logic rst_n;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    monitor_mux_sequencer_if #(.N_CH(N_CH), .ADC_W(ADC_W)) bus ();

    monitor_mux_sequencer #(
        .N_CH(N_CH), .SETTLE_CYCLES(16), .TIMEOUT_CYCLES(255), .ADC_W(ADC_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.start    = 1'b0;
        bus.mode     = 1'b0;
        bus.ch_addr  = '0;
        bus.ch_mask  = '0;
        bus.abort    = 1'b0;
        bus.adc_done = 1'b0;
        bus.adc_data = '0;
    endtask

    function automatic logic [63:0] all_outs();
        return {bus.select, bus.adc_start, bus.busy, bus.result_valid, bus.result_ch,
                bus.result_data, bus.scan_done, bus.err_invalid_ch, bus.err_timeout};
    endfunction

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (all_outs() !== 64'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs got %h want 0", all_outs());
        end
        step(2);
        rst_n = 1'b1;
        step(1);
        vectors++;
        if ({bus.busy, bus.select} !== 41'h0) begin
            miscompares++;
            $display("[TB] FAIL post_reset_idle got busy=%b sel=%h want 0 0", bus.busy, bus.select);
        end
    endtask

    task automatic test_single();
        bus.mode = 1'b0; bus.ch_addr = 6'd5; bus.start = 1'b1;
        step(1);
        bus.start = 1'b0; bus.ch_addr = 6'd7; bus.mode = 1'b1; bus.ch_mask = '1;
        vectors++;
        if ({bus.busy, bus.select} !== {1'b1, 40'h0}) begin
            miscompares++;
            $display("[TB] FAIL single_t1_break got busy=%b sel=%h want 1 0", bus.busy, bus.select);
        end
        step(1);
        vectors++;
        if (bus.select !== 40'h20) begin
            miscompares++;
            $display("[TB] FAIL single_t2_select got %h want 20", bus.select);
        end
        step(15);
        vectors++;
        if (bus.adc_start !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL single_t17_adc_start got %b want 0", bus.adc_start);
        end
        step(1);
        vectors++;
        if (bus.adc_start !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL single_t18_adc_start got %b want 1", bus.adc_start);
        end
        step(1);
        vectors++;
        if (bus.adc_start !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL single_t19_adc_start got %b want 0", bus.adc_start);
        end
        step(2);
        bus.adc_done = 1'b1; bus.adc_data = 12'hABC;
        step(1);
        bus.adc_done = 1'b0; bus.adc_data = 12'h000;
        vectors++;
        if ({bus.result_valid, bus.result_ch, bus.result_data} !== {1'b1, 6'd5, 12'hABC}) begin
            miscompares++;
            $display("[TB] FAIL single_result got v=%b ch=%0d d=%h want 1 5 abc",
                     bus.result_valid, bus.result_ch, bus.result_data);
        end
        step(1);
        vectors++;
        if ({bus.result_valid, bus.busy, bus.result_ch, bus.result_data, bus.select} !==
            {1'b0, 1'b0, 6'd5, 12'hABC, 40'h20}) begin
            miscompares++;
            $display("[TB] FAIL single_idle_hold got v=%b busy=%b ch=%0d d=%h sel=%h want 0 0 5 abc 20",
                     bus.result_valid, bus.busy, bus.result_ch, bus.result_data, bus.select);
        end
        idle_inputs();
    endtask

    task automatic test_invalid();
        int addrs[3] = '{45, 40, 63};
        int bad;
        foreach (addrs[k]) begin
            bus.mode = 1'b0; bus.ch_addr = 6'(addrs[k]); bus.start = 1'b1;
            step(1);
            bus.start = 1'b0;
            vectors++;
            if ({bus.err_invalid_ch, bus.busy, bus.select} !== {1'b1, 1'b0, 40'h0}) begin
                miscompares++;
                $display("[TB] FAIL invalid_ch%0d got err=%b busy=%b sel=%h want 1 0 0",
                         addrs[k], bus.err_invalid_ch, bus.busy, bus.select);
            end
            bad = 0;
            for (int i = 0; i < 20; i++) begin
                step(1);
                if (bus.adc_start || bus.busy || bus.err_invalid_ch) bad++;
            end
            vectors++;
            if (bad != 0) begin
                miscompares++;
                $display("[TB] FAIL invalid_quiet_ch%0d got %0d active cycles want 0", addrs[k], bad);
            end
        end
        idle_inputs();
    endtask

    task automatic test_scan();
        int exp_ch[3] = '{0, 7, 39};
        int starts, results, pend, gaps, want;
        bit done;
        logic [N_CH-1:0]  prev;
        logic [ADC_W-1:0] pend_data;
        bus.mode = 1'b1; bus.ch_mask = (40'b1 << 39) | (40'b1 << 7) | 40'b1; bus.start = 1'b1;
        step(1);
        bus.start = 1'b0; bus.ch_mask = '0; bus.mode = 1'b0;
        prev = '0; done = 1'b0; starts = 0; results = 0; pend = 0; gaps = 0; pend_data = '0;
        for (int c = 0; c < 300 && !done; c++) begin
            if (prev != '0 && bus.select != '0 && bus.select != prev) gaps++;
            prev = bus.select;
            if (bus.adc_start) begin
                want = (starts < 3) ? exp_ch[starts] : 0;
                vectors++;
                if (starts >= 3 || bus.select !== (40'b1 << want)) begin
                    miscompares++;
                    $display("[TB] FAIL scan_select_%0d got %h want %h", starts, bus.select, 40'b1 << want);
                end
                pend = 3;
                pend_data = 12'(12'h100 + want);
                starts++;
            end
            if (bus.result_valid) begin
                want = (results < 3) ? exp_ch[results] : 63;
                vectors++;
                if ({bus.result_ch, bus.result_data} !== {6'(want), 12'(12'h100 + want)}) begin
                    miscompares++;
                    $display("[TB] FAIL scan_result_%0d got ch=%0d d=%h want %0d %h",
                             results, bus.result_ch, bus.result_data, want, 12'(12'h100 + want));
                end
                results++;
            end
            if (bus.scan_done) begin
                done = 1'b1;
                vectors++;
                if (results != 3 || bus.select !== '0 || bus.busy !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL scan_done got results=%0d sel=%h busy=%b want 3 0 0",
                             results, bus.select, bus.busy);
                end
            end
            bus.adc_done = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    bus.adc_done = 1'b1;
                    bus.adc_data = pend_data;
                end
            end
            if (!done) step(1);
        end
        bus.adc_done = 1'b0;
        if (!done) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL scan_timeout got no scan_done want scan_done within 300 cycles");
        end
        vectors++;
        if (gaps != 0) begin
            miscompares++;
            $display("[TB] FAIL scan_break got %0d direct channel switches want 0", gaps);
        end
        idle_inputs();
    endtask

    task automatic test_timeout();
        int err_at, rv, errs, results, starts, pend;
        bit done;
        logic [5:0] last_ch;
        // Scan over channels 2 and 4: channel 2 never answers, channel 4 does.
        bus.mode = 1'b1; bus.ch_mask = 40'h14; bus.start = 1'b1;
        step(1);
        bus.start = 1'b0; bus.ch_mask = '0;
        errs = 0; results = 0; starts = 0; pend = 0; done = 1'b0; last_ch = '1;
        for (int c = 0; c < 700 && !done; c++) begin
            if (bus.adc_start) begin
                starts++;
                if (starts == 2) pend = 3;
            end
            if (bus.err_timeout) begin
                errs++;
                vectors++;
                if ({bus.busy, bus.select} !== {1'b1, 40'h0}) begin
                    miscompares++;
                    $display("[TB] FAIL scan_timeout_break got busy=%b sel=%h want 1 0", bus.busy, bus.select);
                end
            end
            if (bus.result_valid) begin
                results++;
                last_ch = bus.result_ch;
            end
            if (bus.scan_done) done = 1'b1;
            bus.adc_done = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    bus.adc_done = 1'b1;
                    bus.adc_data = 12'h444;
                end
            end
            if (!done) step(1);
        end
        bus.adc_done = 1'b0;
        vectors++;
        if (!done || errs != 1 || results != 1 || last_ch !== 6'd4 || bus.result_data !== 12'h444) begin
            miscompares++;
            $display("[TB] FAIL scan_timeout_next got done=%b errs=%0d results=%0d ch=%0d d=%h want 1 1 1 4 444",
                     done, errs, results, last_ch, bus.result_data);
        end

        // Single channel 3 never answers: WAIT entered at t19, error pulse 255 cycles later.
        bus.mode = 1'b0; bus.ch_addr = 6'd3; bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        err_at = -1; rv = 0;
        for (int c = 1; c < 320 && err_at < 0; c++) begin
            if (bus.result_valid) rv++;
            if (bus.err_timeout) begin
                err_at = c;
                vectors++;
                if ({bus.busy, bus.select} !== {1'b0, 40'h8}) begin
                    miscompares++;
                    $display("[TB] FAIL single_timeout_idle got busy=%b sel=%h want 0 8", bus.busy, bus.select);
                end
            end
            if (err_at < 0) step(1);
        end
        vectors++;
        if (err_at != 274) begin
            miscompares++;
            $display("[TB] FAIL single_timeout_cycle got t%0d want t274", err_at);
        end
        vectors++;
        if (rv != 0) begin
            miscompares++;
            $display("[TB] FAIL single_timeout_result got %0d result strobes want 0", rv);
        end
        step(1);
        vectors++;
        if (bus.err_timeout !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL single_timeout_pulse got %b want 0", bus.err_timeout);
        end
        idle_inputs();
    endtask

    task automatic test_abort();
        int bad;
        // Channel 3 is still routed from the previous single-mode run.
        bus.abort = 1'b1;
        step(1);
        bus.abort = 1'b0;
        vectors++;
        if ({bus.select, bus.busy} !== 41'h0) begin
            miscompares++;
            $display("[TB] FAIL abort_idle got sel=%h busy=%b want 0 0", bus.select, bus.busy);
        end
        bus.mode = 1'b0; bus.ch_addr = 6'd2; bus.start = 1'b1; bus.abort = 1'b1;
        step(1);
        bus.start = 1'b0; bus.abort = 1'b0;
        step(3);
        vectors++;
        if ({bus.select, bus.busy} !== 41'h0) begin
            miscompares++;
            $display("[TB] FAIL abort_beats_start got sel=%h busy=%b want 0 0", bus.select, bus.busy);
        end
        bus.mode = 1'b0; bus.ch_addr = 6'd9; bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        step(9);
        vectors++;
        if ({bus.busy, bus.select} !== {1'b1, 40'h200}) begin
            miscompares++;
            $display("[TB] FAIL abort_settle_entry got busy=%b sel=%h want 1 200", bus.busy, bus.select);
        end
        bus.abort = 1'b1; bus.start = 1'b1;
        step(1);
        bus.abort = 1'b0; bus.start = 1'b0;
        vectors++;
        if ({bus.select, bus.busy, bus.adc_start} !== 42'h0) begin
            miscompares++;
            $display("[TB] FAIL abort_settle got sel=%h busy=%b adc_start=%b want 0 0 0",
                     bus.select, bus.busy, bus.adc_start);
        end
        bad = 0;
        for (int i = 0; i < 25; i++) begin
            step(1);
            if (bus.adc_start || bus.busy || bus.result_valid || bus.scan_done ||
                bus.err_invalid_ch || bus.err_timeout) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("[TB] FAIL abort_quiet got %0d active cycles want 0", bad);
        end
        idle_inputs();
    endtask

    task automatic test_reset_in_wait();
        bit got;
        bus.mode = 1'b0; bus.ch_addr = 6'd6; bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        step(19);
        vectors++;
        if ({bus.busy, bus.select} !== {1'b1, 40'h40}) begin
            miscompares++;
            $display("[TB] FAIL wait_entry got busy=%b sel=%h want 1 40", bus.busy, bus.select);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (all_outs() !== 64'h0) begin
            miscompares++;
            $display("[TB] FAIL async_reset got %h want 0", all_outs());
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.adc_done = 1'b1; bus.adc_data = 12'h555;
        step(1);
        bus.adc_done = 1'b0;
        step(1);
        vectors++;
        if ({bus.result_valid, bus.busy, bus.result_data} !== {1'b0, 1'b0, 12'h000}) begin
            miscompares++;
            $display("[TB] FAIL late_done got v=%b busy=%b d=%h want 0 0 000",
                     bus.result_valid, bus.busy, bus.result_data);
        end
        bus.mode = 1'b0; bus.ch_addr = 6'd1; bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 60 && !got; c++) begin
            if (bus.adc_start) begin
                step(1);
                bus.adc_done = 1'b1; bus.adc_data = 12'h321;
                step(1);
                bus.adc_done = 1'b0;
            end
            if (bus.result_valid) begin
                got = 1'b1;
                vectors++;
                if ({bus.result_ch, bus.result_data, bus.select} !== {6'd1, 12'h321, 40'h2}) begin
                    miscompares++;
                    $display("[TB] FAIL restart_result got ch=%0d d=%h sel=%h want 1 321 2",
                             bus.result_ch, bus.result_data, bus.select);
                end
            end else begin
                step(1);
            end
        end
        if (!got) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL restart_timeout got no result want result within 60 cycles");
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single();
        test_invalid();
        test_scan();
        test_timeout();
        test_abort();
        test_reset_in_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog got no completion want finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
